bus_xfer_unit: RTL
==================

Name: bus_xfer_unit

Overview:
Parametrised successor to the micro's output-bus selector. It latches an operand pair chosen by sel_outbus and runs one complete memory bus transaction (write or read) with a req/ack handshake, wait states and a timeout. It sits between the register file/immediate path and the external data memory, and returns read data and status to the control unit.

Parameters:
DATA_W, 8, width of data bus, rx and num operands
ADDR_W, 8, width of address bus; address taken from ry[ADDR_W-1:0]
TIMEOUT, 15, max cycles in REQ without mem_ack before error (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a transaction
sel_outbus  in  2  00 NOP, 01 write rx to [ry], 10 write num to [ry], 11 read [ry]
rx  in  DATA_W  register operand X (write data)
ry  in  DATA_W  register operand Y (address source)
num  in  DATA_W  immediate operand (write data)
o_direccion_datos  out  ADDR_W  memory address
o_salida_datos  out  DATA_W  memory write data
rw  out  1  1 = write, 0 = read
mem_req  out  1  transaction request to memory
mem_ack  in  1  memory completion strobe
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
rd_data  out  DATA_W  captured read data
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
err  out  1  timeout flag

Behaviour:
- Reset (async, rst=1): state IDLE; o_direccion_datos, o_salida_datos, rd_data, timeout counter = 0; rw, mem_req, busy, done, err = 0. Reset mid-transaction aborts immediately; mem_req drops in the same instant.
- All outputs registered; counter width $clog2(TIMEOUT+1).
- States: IDLE, SETUP, REQ, DONE.
- IDLE: busy=0. start=1 with sel_outbus!=00 -> latch address=ry[ADDR_W-1:0]; data=rx (01), num (10), 0 (11); rw=1 for 01/10, 0 for 11; clear err; clear counter; -> SETUP. start=1 with sel_outbus=00 ignored (no done, no state change).
- SETUP: one cycle, busy=1, mem_req=0, address/data/rw stable. -> REQ.
- REQ: mem_req=1, busy=1. Each cycle sample mem_ack: if 1 -> for read capture rd_data=mem_rdata; -> DONE. If 0 -> counter+1; when counter reaches TIMEOUT with no ack -> err=1, rd_data unchanged, -> DONE. Ack and timeout in same cycle: ack wins, err=0.
- DONE: mem_req=0, done=1 for exactly one cycle, busy=1. -> IDLE.
- Latency: start in cycle 0, SETUP cycle 1, REQ from cycle 2; ack in cycle 2 gives done in cycle 3, busy low in cycle 4. Each wait cycle adds one.
- start while busy=1 ignored; operand changes after acceptance have no effect.
- o_direccion_datos, o_salida_datos, rw hold last values in IDLE; rd_data holds until next successful read; err holds until next accepted start.
- mem_ack outside REQ ignored.

Test Plan:
- Reset: rst=1 with random inputs -> all outputs 0; rst released, no start -> stays IDLE, busy=0.
- Write rx: rx=5, ry=6, sel=01, start pulse, mem_ack at first REQ cycle -> address=6, data=5, rw=1, mem_req high cycle 2 only, done cycle 3, err=0.
- Write num / read: num=2, ry=6, sel=10 -> data=2, rw=1; then sel=11, ry=6, mem_rdata=0xA5 with ack after 3 wait cycles -> rd_data=0xA5, done 3 cycles later than zero-wait case, rw=0, data=0.
- Timeout: sel=11, never ack -> mem_req high TIMEOUT cycles, err=1 with done, rd_data unchanged; next accepted start clears err.
- Ignored starts: sel=00 start -> no busy/done; start during REQ with new operands -> current transaction unaffected, no second transaction.
- Reset mid-op: rst asserted in REQ -> mem_req, busy drop immediately, outputs 0, next start behaves normally.

Source files
------------

// File: rtl/bus_xfer_unit.sv
// -----------------------------------------------------------------------------
// bus_xfer_unit
//
// Latches an operand pair chosen by sel_outbus and runs exactly one memory bus
// transaction (write or read) using a req/ack handshake with wait states and
// a timeout.
//
// Transaction timeline, where cycle 0 is the cycle in which start is accepted:
//   cycle 1      SETUP: address, data and rw are stable; mem_req is low
//   cycle 2..    REQ:   mem_req is high until mem_ack is seen or the
//                       timeout expires
//   after REQ    DONE:  done pulses for one cycle
//   then         IDLE
// busy is high from SETUP through DONE.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, sel_outbus   transaction request and operand select
//                       (00 none, 01 write rx, 10 write num, 11 read)
//   rx, ry, num         operands; the address is taken from ry[ADDR_W-1:0]
//   o_direccion_datos   memory address
//   o_salida_datos      memory write data
//   rw                  1 = write, 0 = read
//   mem_req             request strobe towards memory
//   mem_ack, mem_rdata  completion strobe and read data from memory
//   rd_data             last successfully read data
//   busy, done, err     status: in progress, one-cycle completion pulse,
//                       timeout flag
//
// Every output is driven directly by a flop. ADDR_W must not exceed DATA_W.
// -----------------------------------------------------------------------------
module bus_xfer_unit #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        sel_outbus,
    input  logic [DATA_W-1:0] rx,
    input  logic [DATA_W-1:0] ry,
    input  logic [DATA_W-1:0] num,
    output logic [ADDR_W-1:0] o_direccion_datos,
    output logic [DATA_W-1:0] o_salida_datos,
    output logic              rw,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_REQ   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // A start with the NOP select is dropped outright.
                if (start && (sel_outbus != 2'b00)) begin
                    addr_d = ry[ADDR_W-1:0];
                    unique case (sel_outbus)
                        2'b01:   wdata_d = rx;
                        2'b10:   wdata_d = num;
                        default: wdata_d = '0;
                    endcase
                    rw_d    = (sel_outbus != 2'b11);
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                // The ack is tested first, so an ack in the last allowed
                // cycle still counts as a success.
                if (mem_ack) begin
                    if (!rw_q) begin
                        rd_data_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The strobes are decoded from the next state, so the registered
        // outputs line up with the state they describe.
        busy_d    = (state_d != ST_IDLE);
        mem_req_d = (state_d == ST_REQ);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            mem_req_q <= 1'b0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            mem_req_q <= mem_req_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_direccion_datos = addr_q;
    assign o_salida_datos    = wdata_q;
    assign rw                = rw_q;
    assign mem_req           = mem_req_q;
    assign rd_data           = rd_data_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

endmodule
